// File: rtl/mod_red_pkg.sv
// Shared constants and helpers for the Montgomery reducer output stage.
package mod_red_pkg;

  localparam int CORR_LAT = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < value; i++) r = i + 1;
    return r;
  endfunction

  // Two reducer iterations of sum/mul/sub register groups, the output register,
  // and one or two cycles for the q-high path depending on its mode.
  function automatic int red_lat(input int qh_mode, input int ff_sum, input int ff_mul,
                                 input int ff_sub, input int ff_out);
    return 2 * (ff_mul + ff_sum + ff_sub) + ff_out + ((qh_mode != 0) ? 2 : 1);
  endfunction

endpackage

// File: rtl/mod_red_csub.sv
// Two-stage split conditional subtractor: maps t in [0, 2q) to [0, q), carrying a valid tag.
module mod_red_csub
  import mod_red_pkg::*;
#(
  parameter int Q_LEN = 60,
  parameter int SPLIT = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_LEN-1:0] q,
  input  logic             vld,
  input  logic [Q_LEN-1:0] t,
  output logic             vld_p2,
  output logic [Q_LEN-1:0] res_p2
);

  localparam int HI_W = Q_LEN - SPLIT;

  function automatic logic [Q_LEN-1:0] csel(input logic borrow,
                                            input logic [Q_LEN-1:0] keep,
                                            input logic [Q_LEN-1:0] diff);
    return borrow ? keep : diff;
  endfunction

  logic             vld_p1;
  logic [SPLIT:0]   lo_p1;
  logic [Q_LEN-1:0] t_p1;
  logic [HI_W:0]    hi;

  // Stage 1: low-part difference with its borrow, forward t
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld;
  end

  always_ff @(posedge clk) begin
    lo_p1 <= {1'b0, t[SPLIT-1:0]} - {1'b0, q[SPLIT-1:0]};
    t_p1  <= t;
  end

  // Stage 2: high part absorbs the low borrow; final borrow means t < q
  always_comb begin
    hi = {1'b0, t_p1[Q_LEN-1:SPLIT]} - {1'b0, q[Q_LEN-1:SPLIT]}
         - {{HI_W{1'b0}}, lo_p1[SPLIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    res_p2 <= csel(hi[HI_W], t_p1, {hi[HI_W-1:0], lo_p1[SPLIT-1:0]});
  end

endmodule

// File: rtl/mod_red_out_stage.sv
// Reducer output stage: valid-tag pipeline, conditional subtract, credit-throttled output FIFO.
module mod_red_out_stage
  import mod_red_pkg::*;
#(
  parameter int Q_LEN      = 60,
  parameter int RED_LAT    = red_lat(0, 1, 2, 1, 1),
  parameter int FIFO_DEPTH = 8,
  parameter int SPLIT      = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_LEN-1:0] q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_LEN-1:0] t_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_LEN-1:0] out_data
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int OCC_W = clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  logic               acc, pop, wr;
  logic [OCC_W-1:0]   occ;
  logic [RED_LAT-1:0] tag_sr;
  logic               tag_r;
  logic [Q_LEN-1:0]   res;

  // Credits cover in-flight operands too, so the reducer never has to stall.
  assign in_ready = (occ < DEPTH_C);
  assign acc      = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else if (acc && !pop) begin
      occ <= occ + OCC_W'(1);
    end else if (!acc && pop) begin
      occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tag_sr <= '0;
    else     tag_sr <= (tag_sr << 1) | RED_LAT'(acc);
  end

  assign tag_r = tag_sr[RED_LAT-1];

  mod_red_csub #(
    .Q_LEN (Q_LEN),
    .SPLIT (SPLIT)
  ) u_csub (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .vld    (tag_r),
    .t      (t_in),
    .vld_p2 (wr),
    .res_p2 (res)
  );

  logic [Q_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr, rptr_nxt;
  logic [OCC_W-1:0] cnt, cnt_nxt;

  assign rptr_nxt = rptr + PTR_W'(1);

  always_comb begin
    cnt_nxt = cnt;
    if (wr && !pop)      cnt_nxt = cnt + OCC_W'(1);
    else if (!wr && pop) cnt_nxt = cnt - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= res;
  end

  // out_data mirrors mem[rptr]; reload it whenever the head entry changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr)  wptr <= wptr + PTR_W'(1);
      if (pop) rptr <= rptr_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
      if (pop) begin
        if (cnt > OCC_W'(1)) out_data <= mem[rptr_nxt];
        else if (wr)         out_data <= res;
      end else if (cnt == '0 && wr) begin
        out_data <= res;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr && !pop && cnt == DEPTH_C));

  a_t_in_range: assert property (@(posedge clk) disable iff (rst)
    tag_r |-> ({1'b0, t_in} < {q, 1'b0}));

endmodule

// File: tb/tb_mod_red_out_stage.sv
// Directed bench for mod_red_out_stage with an ideal fixed-latency reducer stub.
module tb_mod_red_out_stage;

  localparam int QW    = 60;
  localparam int RL    = 10;
  localparam int DEPTH = 8;
  localparam int LAT   = RL + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [QW-1:0] q, t_in, out_data, c_in;
  logic [QW-1:0] pipe [RL];
  logic [QW-1:0] vals [8];
  logic [QW-1:0] exps [8];
  logic [QW-1:0] sb [$];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  // Reducer stub: T equals the issued C, RL cycles later
  always @(posedge clk) begin
    pipe[0] <= c_in;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign t_in = pipe[RL-1];

  mod_red_out_stage #(
    .Q_LEN      (QW),
    .RED_LAT    (RL),
    .FIFO_DEPTH (DEPTH),
    .SPLIT      (30)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t_in      (t_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic issue(input logic [QW-1:0] t);
    in_valid = 1'b1;
    c_in     = t;
    @(negedge clk);
    in_valid = 1'b0;
    c_in     = '0;
  endtask

  task automatic collect(output logic [QW-1:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (out_valid) begin
        v  = out_data;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = '0;
    q = 60'hFFF_FFFF_FFFF_FFC5;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int edges;
    q = 60'hFFF_FFFF_FFFF_FFC5;
    out_ready = 1'b0;
    in_valid = 1'b1; c_in = 60'hFFF_FFFF_FFFF_FFCA;
    @(negedge clk);
    in_valid = 1'b0; c_in = '0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checks++; if (edges != LAT) begin failures++; $display("FAIL latency: got %0d cycles expected %0d", edges, LAT); end
    checks++; if (out_data !== 60'h5) begin failures++; $display("FAIL q_plus_5: got %h expected 5", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pop_empty: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_boundaries();
    logic [QW-1:0] v;
    logic [QW-1:0] exp_b [4];
    bit ok;
    exp_b = '{60'h0, 60'h7FF_FFFF_FFFF_FFC4, 60'h0, 60'h7FF_FFFF_FFFF_FFC4};
    q = 60'h7FF_FFFF_FFFF_FFC5;
    issue(60'h7FF_FFFF_FFFF_FFC5);
    issue(60'h7FF_FFFF_FFFF_FFC4);
    issue(60'h0);
    issue(60'hFFF_FFFF_FFFF_FF89);
    for (int i = 0; i < 4; i++) begin
      collect(v, ok);
      checks++;
      if (!ok || v !== exp_b[i]) begin
        failures++;
        $display("FAIL boundary_%0d: got %h (arrived=%0b) expected %h", i, v, ok, exp_b[i]);
      end
    end
  endtask

  task automatic test_low_borrow();
    logic [QW-1:0] v;
    bit ok;
    q = 60'h400_0000_7FFF_FFFF;
    issue(60'h400_0001_0000_0000);
    collect(v, ok);
    checks++;
    if (!ok || v !== 60'h0000_0000_8000_0001) begin
      failures++;
      $display("FAIL low_borrow: got %h (arrived=%0b) expected 000000080000001", v, ok);
    end
    q = 60'h7FF_FFFF_FFFF_FFC5;
  endtask

  task automatic test_backpressure();
    int accepts;
    int first_block;
    accepts = 0; first_block = -1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_in = vals[accepts % 8];
      if (in_ready) accepts++;
      else if (first_block < 0) first_block = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0; c_in = '0;
    checks++; if (accepts != DEPTH) begin failures++; $display("FAIL bp_accepts: got %0d expected %0d", accepts, DEPTH); end
    checks++; if (first_block != DEPTH) begin failures++; $display("FAIL bp_first_block: got %0d expected %0d", first_block, DEPTH); end
    repeat (LAT + 2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_blocked: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i]) begin
        failures++;
        $display("FAIL bp_order_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exps[i]);
      end
      @(negedge clk);
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_credit_return: got %b expected 1", in_ready); end
      end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_concurrent();
    int n;
    int accepts;
    logic [QW-1:0] v;
    bit ok;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      issue(vals[n % 8]);
      sb.push_back(exps[n % 8]);
      n++;
    end
    repeat (LAT + 2) @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = out_valid;
      c_in = vals[n % 8];
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cc_in_ready_%0d: got %b expected 1", cyc, in_ready); end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL cc_extra_%0d: got %h expected nothing", cyc, out_data);
        end else begin
          v = sb.pop_front();
          if (out_data !== v) begin failures++; $display("FAIL cc_data_%0d: got %h expected %h", cyc, out_data, v); end
        end
        sb.push_back(exps[n % 8]);
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    // With seven credits held, exactly one more operand fits
    accepts = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      c_in = vals[n % 8];
      if (in_ready) begin
        accepts++;
        sb.push_back(exps[n % 8]);
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; c_in = '0;
    checks++; if (accepts != 1) begin failures++; $display("FAIL cc_occ_held: got %0d accepts expected 1", accepts); end
    while (sb.size() > 0) begin
      collect(v, ok);
      checks++;
      if (!ok || v !== sb[0]) begin
        failures++; $display("FAIL cc_drain: got %h (arrived=%0b) expected %h", v, ok, sb[0]);
      end
      void'(sb.pop_front());
    end
    repeat (LAT) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cc_duplicate: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int stale;
    logic [QW-1:0] v;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(vals[i]);
    repeat (8) @(negedge clk);
    for (int i = 3; i < 8; i++) issue(vals[i]);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_prefill: got out_valid=%b expected 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rm_out_data: got %h expected 0", out_data); end
    stale = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (stale != 0) begin failures++; $display("FAIL rm_stale: got %0d results expected 0", stale); end
    issue(vals[3]);
    collect(v, ok);
    checks++;
    if (!ok || v !== exps[3]) begin
      failures++; $display("FAIL rm_after: got %h (arrived=%0b) expected %h", v, ok, exps[3]);
    end
  endtask

  initial begin
    vals = '{60'h000_0000_0000_0011, 60'h7FF_FFFF_FFFF_FFD5, 60'h123_4567_89AB_CDEF,
             60'h923_4567_89AB_CDEF, 60'h7FF_FFFF_FFFF_FFC6, 60'h000_0000_0000_0000,
             60'hFFF_FFFF_FFFF_FF89, 60'h555_5555_5555_5555};
    exps = '{60'h000_0000_0000_0011, 60'h000_0000_0000_0010, 60'h123_4567_89AB_CDEF,
             60'h123_4567_89AB_CE2A, 60'h000_0000_0000_0001, 60'h000_0000_0000_0000,
             60'h7FF_FFFF_FFFF_FFC4, 60'h555_5555_5555_5555};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = '0;
    q = 60'hFFF_FFFF_FFFF_FFC5;
    test_reset();
    test_latency();
    test_boundaries();
    test_low_borrow();
    test_backpressure();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
